// File: rtl/mic1_register_file.sv
// Mic-1 sixteen-entry register file: one-hot A/B/C selects, A/B output latches,
// hardwired constant registers and registered select/read-only error pulses.
module mic1_register_file #(
    parameter int                DATA_W  = 16,
    parameter logic [DATA_W-1:0] SP_INIT = 16'h0F80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       a_sel,
    input  logic [15:0]       b_sel,
    input  logic [15:0]       c_sel,
    input  logic              enc,
    input  logic              latch_en,
    input  logic [DATA_W-1:0] c_bus,
    output logic [DATA_W-1:0] a_bus,
    output logic [DATA_W-1:0] b_bus,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] ac_out,
    output logic              sel_err,
    output logic              ro_err
);

    localparam int NUM_GPR = 11;

    // Eleven writable slots: indices 0-4 map to slots 0-4, indices 10-15 to slots 5-10.
    logic [DATA_W-1:0] gpr_q [NUM_GPR];
    logic [DATA_W-1:0] gpr_d [NUM_GPR];
    logic [DATA_W-1:0] a_bus_q, a_bus_d;
    logic [DATA_W-1:0] b_bus_q, b_bus_d;
    logic              sel_err_q, sel_err_d;
    logic              ro_err_q, ro_err_d;

    logic [DATA_W-1:0] rf_view [16];
    logic [3:0]        a_idx, b_idx, c_idx;
    logic              a_ok, b_ok, c_ok;

    function automatic logic [3:0] sel_index(input logic [15:0] sel);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (sel[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic is_const(input logic [3:0] idx);
        return (idx >= 4'd5) && (idx <= 4'd9);
    endfunction

    function automatic logic [3:0] slot_of(input logic [3:0] idx);
        return (idx >= 4'd10) ? idx - 4'd5 : idx;
    endfunction

    always_comb begin
        a_ok  = $onehot(a_sel);
        b_ok  = $onehot(b_sel);
        c_ok  = $onehot(c_sel);
        a_idx = sel_index(a_sel);
        b_idx = sel_index(b_sel);
        c_idx = sel_index(c_sel);
    end

    // Architectural view: constants are plain wiring, never storage.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            rf_view[i] = '0;
        end
        for (int i = 0; i < 5; i++) begin
            rf_view[i] = gpr_q[i];
        end
        rf_view[5] = '0;
        rf_view[6] = DATA_W'(1);
        rf_view[7] = {DATA_W{1'b1}};
        rf_view[8] = DATA_W'(16'h0FFF);
        rf_view[9] = DATA_W'(16'h00FF);
        for (int i = 10; i < 16; i++) begin
            rf_view[i] = gpr_q[i - 5];
        end
    end

    // Latches read rf_view (pre-write), so a same-cycle write is never bypassed.
    always_comb begin
        a_bus_d   = a_bus_q;
        b_bus_d   = b_bus_q;
        sel_err_d = 1'b0;
        ro_err_d  = 1'b0;
        for (int i = 0; i < NUM_GPR; i++) begin
            gpr_d[i] = gpr_q[i];
        end

        if (latch_en) begin
            a_bus_d = a_ok ? rf_view[a_idx] : '0;
            b_bus_d = b_ok ? rf_view[b_idx] : '0;
            if (!a_ok || !b_ok) sel_err_d = 1'b1;
        end

        if (enc) begin
            if (!c_ok) begin
                sel_err_d = 1'b1;
            end else if (is_const(c_idx)) begin
                ro_err_d = 1'b1;
            end else begin
                gpr_d[slot_of(c_idx)] = c_bus;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= (i == 2) ? SP_INIT : '0;
            end
            a_bus_q   <= '0;
            b_bus_q   <= '0;
            sel_err_q <= 1'b0;
            ro_err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
            a_bus_q   <= a_bus_d;
            b_bus_q   <= b_bus_d;
            sel_err_q <= sel_err_d;
            ro_err_q  <= ro_err_d;
        end
    end

    assign a_bus   = a_bus_q;
    assign b_bus   = b_bus_q;
    assign pc_out  = gpr_q[0];
    assign ac_out  = gpr_q[1];
    assign sel_err = sel_err_q;
    assign ro_err  = ro_err_q;

endmodule

// File: tb/tb_mic1_register_file.sv
// Bench for mic1_register_file: directed and random cycles predicted by an
// array-based model, expectations queued by the driver and checked by a monitor.
module tb_mic1_register_file;

    localparam int W = 16;
    localparam int EXP_W = 4 * W + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  a_sel = '0, b_sel = '0, c_sel = '0;
    logic         enc = 1'b0, latch_en = 1'b0;
    logic [W-1:0] c_bus = '0;
    logic [W-1:0] a_bus, b_bus, pc_out, ac_out;
    logic         sel_err, ro_err;

    int checks = 0;
    int errors = 0;

    logic [EXP_W-1:0] exp_q[$];

    // Reference state: register index -> value, constants included.
    logic [W-1:0] m_reg [16];
    logic [W-1:0] m_a, m_b;
    logic         m_sel, m_ro;

    mic1_register_file dut (
        .clk(clk), .rst(rst),
        .a_sel(a_sel), .b_sel(b_sel), .c_sel(c_sel),
        .enc(enc), .latch_en(latch_en), .c_bus(c_bus),
        .a_bus(a_bus), .b_bus(b_bus), .pc_out(pc_out), .ac_out(ac_out),
        .sel_err(sel_err), .ro_err(ro_err)
    );

    always #5 clk = ~clk;

    function automatic int one_hot_pos(input logic [15:0] s);
        if ($countones(s) != 1) return -1;
        for (int i = 0; i < 16; i++) if (s[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = '0;
        m_reg[2] = 16'h0F80;
        m_reg[6] = 16'h0001;
        m_reg[7] = 16'hFFFF;
        m_reg[8] = 16'h0FFF;
        m_reg[9] = 16'h00FF;
        m_a = '0; m_b = '0; m_sel = 1'b0; m_ro = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic [15:0] as, input logic [15:0] bs,
                              input logic [15:0] cs, input logic e, input logic le,
                              input logic [W-1:0] cb);
        int pa, pb, pc;
        logic [W-1:0] old [16];
        if (r) begin
            model_reset();
            return;
        end
        old = m_reg;
        m_sel = 1'b0;
        m_ro  = 1'b0;
        if (le) begin
            pa = one_hot_pos(as);
            pb = one_hot_pos(bs);
            m_a = (pa < 0) ? '0 : old[pa];
            m_b = (pb < 0) ? '0 : old[pb];
            if (pa < 0 || pb < 0) m_sel = 1'b1;
        end
        if (e) begin
            pc = one_hot_pos(cs);
            if (pc < 0) m_sel = 1'b1;
            else if (pc >= 5 && pc <= 9) m_ro = 1'b1;
            else m_reg[pc] = cb;
        end
    endtask

    // Driver: present inputs on the falling edge, queue what the next rising edge must produce.
    task automatic drive(input logic r, input logic [15:0] as, input logic [15:0] bs,
                         input logic [15:0] cs, input logic e, input logic le,
                         input logic [W-1:0] cb);
        @(negedge clk);
        rst = r; a_sel = as; b_sel = bs; c_sel = cs; enc = e; latch_en = le; c_bus = cb;
        model_step(r, as, bs, cs, e, le, cb);
        exp_q.push_back({m_a, m_b, m_reg[0], m_reg[1], m_sel, m_ro});
    endtask

    task automatic check_field(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: every rising edge after which an expectation is pending.
    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_field("a_bus", a_bus, e[EXP_W-1 -: W]);
                check_field("b_bus", b_bus, e[EXP_W-1-W -: W]);
                check_field("pc_out", pc_out, e[EXP_W-1-2*W -: W]);
                check_field("ac_out", ac_out, e[EXP_W-1-3*W -: W]);
                check_field("sel_err", W'(sel_err), W'(e[1]));
                check_field("ro_err", W'(ro_err), W'(e[0]));
            end
        end
    end

    function automatic logic [15:0] rand_sel();
        if ($urandom_range(0, 11) == 0) return 16'($urandom_range(0, 65535));
        return 16'(1) << $urandom_range(0, 15);
    endfunction

    initial begin
        int wait_cycles;
        model_reset();
        // Reset, then constant and SP reads
        drive(1, '0, '0, '0, 0, 0, '0);
        drive(1, '0, '0, '0, 0, 0, '0);
        drive(0, 16'(1) << 8, 16'(1) << 7, '0, 0, 1, '0);
        drive(0, 16'(1) << 2, 16'(1) << 5, '0, 0, 1, '0);
        // Write then read AC
        drive(0, '0, '0, 16'(1) << 1, 1, 0, 16'h1234);
        drive(0, 16'(1) << 1, 16'(1) << 1, '0, 0, 1, '0);
        // Same-cycle write and latch: latch sees the old value
        drive(0, '0, '0, 16'(1) << 1, 1, 0, 16'h0005);
        drive(0, 16'(1) << 1, 16'(1) << 0, 16'(1) << 1, 1, 1, 16'h00AA);
        drive(0, 16'(1) << 1, 16'(1) << 1, '0, 0, 1, '0);
        // Read-only write, then read of r6
        drive(0, '0, '0, 16'(1) << 6, 1, 0, 16'h7777);
        drive(0, 16'(1) << 6, 16'(1) << 9, '0, 0, 1, '0);
        // Malformed selects, back-to-back errors, then idle so flags clear
        drive(0, 16'h0003, 16'(1) << 1, '0, 0, 1, '0);
        drive(0, '0, '0, 16'h0000, 1, 0, 16'hBEEF);
        drive(0, 16'h0000, 16'(1) << 1, 16'(1) << 8, 1, 1, 16'h1111);
        drive(0, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 0, '0);
        // Reset discards a pending write
        drive(0, '0, '0, 16'(1) << 10, 1, 0, 16'h9999);
        drive(1, 16'(1) << 10, '0, 16'(1) << 10, 1, 1, 16'h5555);
        drive(0, 16'(1) << 10, 16'(1) << 15, '0, 0, 1, '0);
        // Random traffic
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 79) == 0), rand_sel(), rand_sel(), rand_sel(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  W'($urandom_range(0, 65535)));
        end
        drive(0, '0, '0, '0, 0, 0, '0);
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mic1_register_file.md
# mic1_register_file

Sixteen-entry, 16-bit register file of the Mic-1 data path, sitting directly downstream of the 4-to-16 field decoders. It consumes the one-hot A, B and C selects produced by decoding the MIR A/B/C fields. It drives the A and B latches that feed the ALU and writes the C bus back under ENC. It also holds the fixed Mic-1 constant registers and flags malformed selects or writes to read-only entries.

## Interface
- DATA_W, 16: register and bus width.
- SP_INIT, 16'h0F80: reset value of SP.
- clk  input  1  rising-edge clock; only clock of the block.
- rst  input  1  synchronous, active-high reset.
- a_sel  input  16  one-hot A-bus register select, from the A decoder.
- b_sel  input  16  one-hot B-bus register select, from the B decoder.
- c_sel  input  16  one-hot C-bus register select, from the C decoder.
- enc  input  1  C-bus write enable (MIR ENC bit, subcycle 4).
- latch_en  input  1  load A/B latches (subcycle 2).
- c_bus  input  DATA_W  write-back data from the shifter.
- a_bus  output  DATA_W  A-latch contents.
- b_bus  output  DATA_W  B-latch contents.
- pc_out  output  DATA_W  live PC (r0) for MAR/debug.
- ac_out  output  DATA_W  live AC (r1) for debug.
- sel_err  output  1  one-cycle pulse on a malformed select.
- ro_err  output  1  one-cycle pulse on a write to a constant register.

## Operation
- Register map, index = one-hot bit position:
  - 0 PC, 1 AC, 2 SP, 3 IR, 4 TIR: writable.
  - 5 = 16'h0000, 6 = 16'h0001, 7 = 16'hFFFF, 8 AMASK = 16'h0FFF, 9 SMASK = 16'h00FF: read-only constants, hardwired, not flops.
  - 10-15 A-F: writable general registers.
- Reset (rst=1 at edge): PC, AC, IR, TIR, A-F = 0; SP = SP_INIT; a_bus, b_bus = 0; sel_err, ro_err = 0. Reset overrides enc and latch_en in the same cycle.
- Latch load: on an edge with latch_en=1, a_bus <= reg[a_sel] and b_bus <= reg[b_sel]. Latches hold otherwise.
- Write: on an edge with enc=1, reg[c_sel] <= c_bus.
- One-hot check: a select is valid only if exactly one bit is set; all-zero is invalid.
  - Invalid a_sel or b_sel with latch_en=1: that latch loads 0 and sel_err pulses.
  - Invalid c_sel with enc=1: no register is written and sel_err pulses.
  - Selects are ignored when their enable is low; no error is flagged.
- Write to index 5-9 with a valid c_sel: no state change and ro_err pulses.
- sel_err and ro_err may pulse in the same cycle.
- pc_out and ac_out are direct register outputs.

## Timing
- Latch-load latency is 1 cycle: the value is visible on a_bus/b_bus after the latch_en edge.
- Write latency is 1 cycle: the register, pc_out and ac_out show the new value after the enc edge.
- latch_en and enc in the same cycle on the same register: the latch captures the old (pre-write) value. There is no write-through bypass.
- Read of a register one cycle after its write returns the new value.
- a_sel == b_sel is legal; both latches receive the same value.
- sel_err/ro_err are registered, asserted for exactly one cycle after the offending edge, then 0 unless re-triggered. Back-to-back errors keep the flag high.
- Reset mid-operation: any write or latch load pending in the reset cycle is discarded.
- The block has no combinational path from any input to any output.

## Test plan
- Reset: assert rst 2 cycles → a_bus=b_bus=0, pc_out=ac_out=0, SP reads 16'h0F80, flags 0. Latching a_sel=1<<8, b_sel=1<<7 → a_bus=16'h0FFF, b_bus=16'hFFFF.
- Write/read: enc, c_sel=1<<1, c_bus=16'h1234, then latch_en with a_sel=1<<1 → ac_out=16'h1234 after the first edge, a_bus=16'h1234 after the second.
- Same-cycle hazard: AC=16'h0005; in one cycle assert enc (AC←16'h00AA) and latch_en (a_sel=AC) → a_bus=16'h0005, ac_out=16'h00AA. A latch one cycle later gives 16'h00AA.
- Read-only write: enc, c_sel=1<<6, c_bus=16'h7777 → ro_err pulses 1 cycle, and a later latch of r6 reads 16'h0001.
- Malformed selects: latch_en with a_sel=16'h0003 → a_bus=0 and sel_err pulses. enc with c_sel=0, c_bus=16'hBEEF → no register changes and sel_err pulses.
- Reset mid-write: enc, c_sel=1<<10, c_bus=16'h5555 with rst=1 → register A reads 0 afterwards and no flag is raised.
